// File: rtl/tpu_systolic_sequencer_if.sv
// Host/array-side signal bundle for tpu_systolic_sequencer.
// The host drives the master modport and the sequencer uses the slave modport.
interface tpu_systolic_sequencer_if #(
  parameter int bit_width = 8
);
  logic                   start;
  logic [7:0]             num_vecs;
  logic                   w_valid;
  logic                   w_ready;
  logic [4*bit_width-1:0] w_row;
  logic                   a_valid;
  logic                   a_ready;
  logic [4*bit_width-1:0] a_vec;
  logic                   ld_w_en;
  logic [1:0]             ld_w_id;
  logic [4*bit_width-1:0] w_out;
  logic [4*bit_width-1:0] a_out;
  logic [3:0]             res_valid;
  logic                   busy;
  logic                   done;

  modport master (
    output start, num_vecs, w_valid, w_row, a_valid, a_vec,
    input  w_ready, a_ready, ld_w_en, ld_w_id, w_out, a_out, res_valid, busy, done
  );

  modport slave (
    input  start, num_vecs, w_valid, w_row, a_valid, a_vec,
    output w_ready, a_ready, ld_w_en, ld_w_id, w_out, a_out, res_valid, busy, done
  );
endinterface

// File: rtl/tpu_systolic_sequencer.sv
// Weight-load / skewed-activation feed sequencer for a 4x4 weight-stationary array.
// Optional TPU_SEQ_PERF_EN adds saturating busy-cycle and stall counters.
module tpu_seq_lane #(
  parameter int W    = 8,
  parameter int SKEW = 1,
  parameter int LAT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  input  logic         tag,
  output logic [W-1:0] q,
  output logic         res_vld
);
  localparam int STAGES = SKEW + LAT;

  logic [SKEW:1][W-1:0] dpipe;
  logic [STAGES:1]      vld_pipe;

  // dpipe[1] is the newest stage; data leaves from dpipe[SKEW]
  if (SKEW == 1) begin : g_one
    always_ff @(posedge clk)
      if (rst) dpipe <= '0;
      else     dpipe <= d;
  end else begin : g_many
    always_ff @(posedge clk)
      if (rst) dpipe <= '0;
      else     dpipe <= {dpipe[SKEW-1:1], d};
  end

  always_ff @(posedge clk)
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], tag};

  assign q       = dpipe[SKEW];
  assign res_vld = vld_pipe[STAGES];
endmodule

module tpu_systolic_sequencer #(
  parameter int bit_width = 8,
  parameter int ARRAY_LAT = 4
) (
`ifdef TPU_SEQ_PERF_EN
  output logic [15:0] perf_cycles,
  output logic [15:0] perf_stalls,
`endif
  input  logic clk,
  input  logic rst,
  tpu_systolic_sequencer_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = bit_width;
  localparam int DW        = $clog2(ARRAY_LAT + 5);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ARRAY_LAT + 4);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [7:0]    vec_cnt, acc_cnt;
  logic [1:0]    row_cnt;
  logic [DW-1:0] drain_cnt;
  logic          w_fire, a_fire;
  logic          ld_w_en_q;
  logic [1:0]    ld_w_id_q;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_out_q, lane_in, lane_out;
  logic [NUM_LANES-1:0]            res_vld;

  assign w_fire  = bus.w_valid && (state == S_LOAD_W);
  assign a_fire  = bus.a_valid && (state == S_STREAM);
  // Idle slots in the stream still shift zeros with a cleared tag
  assign lane_in = a_fire ? bus.a_vec : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec_cnt   <= '0;
      acc_cnt   <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= '0;
      case (state)
        S_IDLE: if (bus.start) begin
          vec_cnt <= bus.num_vecs;
          row_cnt <= '0;
          acc_cnt <= '0;
          state   <= S_LOAD_W;
        end
        S_LOAD_W: if (w_fire) begin
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'd3) state <= (vec_cnt != 8'd0) ? S_STREAM : S_DRAIN;
        end
        S_STREAM: if (a_fire) begin
          acc_cnt <= acc_cnt + 8'd1;
          if (acc_cnt + 8'd1 == vec_cnt) state <= S_DRAIN;
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (drain_cnt == DRAIN_LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_w_en_q <= 1'b0;
      ld_w_id_q <= '0;
      w_out_q   <= '0;
    end else begin
      ld_w_en_q <= w_fire;
      if (w_fire) begin
        ld_w_id_q <= row_cnt;
        w_out_q   <= bus.w_row;
      end
    end
  end

  // Lane k sits k+1 stages behind the input; its tag rides ARRAY_LAT further
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    tpu_seq_lane #(.W(VEC_W), .SKEW(k + 1), .LAT(ARRAY_LAT)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .d       (lane_in[k]),
      .tag     (a_fire),
      .q       (lane_out[k]),
      .res_vld (res_vld[k])
    );
  end

  assign bus.w_ready   = (state == S_LOAD_W);
  assign bus.a_ready   = (state == S_STREAM);
  assign bus.ld_w_en   = ld_w_en_q;
  assign bus.ld_w_id   = ld_w_id_q;
  assign bus.w_out     = w_out_q;
  assign bus.a_out     = lane_out;
  assign bus.res_valid = res_vld;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);

`ifdef TPU_SEQ_PERF_EN
  logic stall;
  assign stall = ((state == S_LOAD_W) && !bus.w_valid) || ((state == S_STREAM) && !bus.a_valid);

  always_ff @(posedge clk) begin
    if (rst || ((state == S_IDLE) && bus.start)) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_cycles != 16'hFFFF)) perf_cycles <= perf_cycles + 16'd1;
      if (stall && (perf_stalls != 16'hFFFF))            perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_tpu_systolic_sequencer.sv
// Scoreboard bench for tpu_systolic_sequencer: a cycle-level job model predicts
// handshakes, weight loads, skewed activations, result strobes and done timing.
module tb_tpu_systolic_sequencer;
  localparam int L   = 4;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  tpu_systolic_sequencer_if #(.bit_width(8)) bus ();
`ifdef TPU_SEQ_PERF_EN
  logic [15:0] perf_cycles, perf_stalls;
`endif

  tpu_systolic_sequencer #(.bit_width(8), .ARRAY_LAT(L)) dut (
`ifdef TPU_SEQ_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
`endif
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Job model: the sequence of accepted beats fully determines every output
  typedef struct { int cyc; logic [1:0] id; logic [31:0] row; } ld_t;
  ld_t         ld_q[$];
  int          res_q[4][$];
  int          done_q[$];
  logic [31:0] acc_vec[int];
  int job_start = BIG, job_end = -1, job_n = 0;
  int rows_acc = 0, vecs_acc = 0, m_cycles = 0, m_stalls = 0;

  function automatic bit in_job(input int c);
    return (c >= job_start) && (c <= job_end);
  endfunction
  function automatic bit ew(input int c);
    return in_job(c) && (rows_acc < 4);
  endfunction
  function automatic bit ea(input int c);
    return in_job(c) && (rows_acc == 4) && (vecs_acc < job_n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic set_done(input int c);
    done_q.push_back(c + L + 6);
    job_end = c + L + 6;
  endtask

  // Advance one cycle: record what the DUT accepts at the coming edge, then drive at posedge+1
  task automatic step();
    @(negedge clk);
    if (rst) begin
      job_start = BIG; job_end = -1; rows_acc = 0; vecs_acc = 0;
      m_cycles = 0; m_stalls = 0;
      ld_q.delete(); done_q.delete(); acc_vec.delete();
      for (int k = 0; k < 4; k++) res_q[k].delete();
    end else begin
      if (in_job(cyc) && m_cycles < 65535) m_cycles++;
      if (((ew(cyc) && !bus.w_valid) || (ea(cyc) && !bus.a_valid)) && m_stalls < 65535) m_stalls++;
      if (bus.start && !in_job(cyc)) begin
        job_start = cyc + 1; job_end = BIG; job_n = int'(bus.num_vecs);
        rows_acc = 0; vecs_acc = 0; m_cycles = 0; m_stalls = 0;
      end else if (bus.w_valid && ew(cyc)) begin
        ld_q.push_back('{cyc + 1, 2'(rows_acc), bus.w_row});
        rows_acc++;
        if (rows_acc == 4 && job_n == 0) set_done(cyc);
      end else if (bus.a_valid && ea(cyc)) begin
        acc_vec[cyc] = bus.a_vec;
        for (int k = 0; k < 4; k++) res_q[k].push_back(cyc + 1 + k + L);
        vecs_acc++;
        if (vecs_acc == job_n) set_done(cyc);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output once per cycle against the model
  always @(posedge clk) begin
    logic [31:0] v;
    bit e;
    #3;
    if (chk_en) begin
      e = (ld_q.size() > 0) && (ld_q[0].cyc == cyc);
      chk("ld_w_en", bus.ld_w_en, e);
      if (e) begin
        chk("ld_w_id", bus.ld_w_id, ld_q[0].id);
        chk("w_out", bus.w_out, ld_q[0].row);
        ld_q.delete(0);
      end
      for (int k = 0; k < 4; k++) begin
        v = acc_vec.exists(cyc - 1 - k) ? acc_vec[cyc - 1 - k] : 32'h0;
        chk($sformatf("a_out_lane%0d", k), bus.a_out[k*8 +: 8], v[k*8 +: 8]);
        e = (res_q[k].size() > 0) && (res_q[k][0] == cyc);
        chk($sformatf("res_valid%0d", k), bus.res_valid[k], e);
        if (e) res_q[k].delete(0);
      end
      e = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", bus.done, e);
      if (e) done_q.delete(0);
      chk("busy", bus.busy, in_job(cyc));
      chk("w_ready", bus.w_ready, ew(cyc));
      chk("a_ready", bus.a_ready, ea(cyc));
    end
  end

  // mode 0: back-to-back, mode 1: 2-cycle gap after first vector, mode 2: random
  task automatic run_job(input int n, input int mode, input int bound,
                         input bit inj_start, input bit inj_rst, input int wdelay);
    int t;
    int gap_left;
    bit start_sent;
    t = 0; gap_left = 2; start_sent = 1'b0;
    bus.start = 1'b1; bus.num_vecs = 8'(n);
    step();
    bus.start = 1'b0; bus.num_vecs = 8'($urandom);
    while (cyc <= job_end + 2) begin
      if (t > bound) begin
        nvec++; nerr++;
        $display("FAIL job_timeout cyc=%0d got=no_done exp=done_within_%0d", cyc, bound);
        break;
      end
      t++;
      if (mode == 2) begin
        bus.w_valid = ($urandom % 3) != 0;
        bus.w_row   = $urandom;
        bus.a_valid = ($urandom % 3) != 0;
        bus.a_vec   = $urandom;
      end else begin
        bus.w_valid = (rows_acc < 4) && (t > wdelay);
        bus.w_row   = {4{8'(rows_acc + 1)}};
        bus.a_valid = vecs_acc < n;
        bus.a_vec   = 32'h11223344 + 32'(vecs_acc) * 32'h01010101;
        if (mode == 1 && vecs_acc == 1 && gap_left > 0) begin
          bus.a_valid = 1'b0;
          gap_left--;
        end
      end
      bus.start = 1'b0;
      if (inj_start && !start_sent && vecs_acc == 1) begin
        bus.start = 1'b1;
        start_sent = 1'b1;
      end
      rst = inj_rst && (job_end != BIG) && (cyc == job_end - 4);
      step();
    end
    bus.w_valid = 1'b0; bus.a_valid = 1'b0; bus.start = 1'b0; rst = 1'b0;
`ifdef TPU_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, m_cycles);
    chk("perf_stalls", perf_stalls, m_stalls);
`endif
  endtask

  initial begin
    bus.start = 1'b0; bus.num_vecs = '0;
    bus.w_valid = 1'b0; bus.w_row = '0;
    bus.a_valid = 1'b0; bus.a_vec = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();

    run_job(2, 0, 200, 1'b0, 1'b0, 0);
    repeat (2) step();
    run_job(2, 1, 200, 1'b0, 1'b0, 0);
    run_job(0, 0, 200, 1'b0, 1'b0, 0);
    run_job(3, 0, 200, 1'b1, 1'b1, 0);
    repeat (3) step();
    for (int i = 0; i < 12; i++) run_job($urandom_range(0, 12), 2, 2000, 1'($urandom % 2), 1'b0, 0);
`ifdef TPU_SEQ_PERF_EN
    run_job(0, 0, 70000, 1'b0, 1'b0, 66000);
`endif
    repeat (2) step();
    chk("pending_ld", ld_q.size(), 0);
    chk("pending_res", res_q[0].size() + res_q[1].size() + res_q[2].size() + res_q[3].size(), 0);
    chk("pending_done", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tpu_systolic_sequencer.md
# tpu_systolic_sequencer

Control and feed sequencer for the 4x4 weight-stationary systolic array and its quantizer/activation back end. It accepts one job per `start`, loads four weight rows into the array through `ld_w_id`/`ld_w_en`, and streams a programmable number of activation vectors with the per-lane diagonal skew the array requires. It then drains the pipeline and produces per-lane result-valid strobes aligned to the array outputs. It sits between the host-side buffers (valid/ready producers) and the array top level.

## Interface
- `bit_width`, 8, element width of weights and activations
- `ARRAY_LAT`, 4, cycles from a lane-0 activation at the array input to the matching lane-0 value at the array output; must be ≥ 1
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `start`  in  1  single-cycle job request; honoured only in IDLE
- `num_vecs`  in  8  activation vectors per job; sampled on an accepted `start`
- `w_valid` / `w_ready`  in / out  1 / 1  weight-row handshake
- `w_row`  in  4*bit_width  one weight row; lane k = bits [k*bit_width +: bit_width]
- `a_valid` / `a_ready`  in / out  1 / 1  activation-vector handshake
- `a_vec`  in  4*bit_width  one activation vector; same lane packing
- `ld_w_en`  out  1  weight-load strobe to the array
- `ld_w_id`  out  2  weight row index, 0..3
- `w_out`  out  4*bit_width  weight row to the array `w_in_1..4`
- `a_out`  out  4*bit_width  skewed activations to the array `a_in_1..4`
- `res_valid`  out  4  bit k is high when array output lane k carries a valid result
- `busy`  out  1  high from accepted `start` through the DONE state
- `done`  out  1  one-cycle pulse at the end of a job

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - All handshake readies are 0.
  - `start` latches `num_vecs` into `vec_cnt`, clears `row_cnt`, and moves to LOAD_W.
- LOAD_W:
  - `w_ready` = 1.
  - Each `w_valid & w_ready` beat drives `ld_w_en`=1, `ld_w_id`=`row_cnt`, `w_out`=`w_row` on the next cycle (registered), then increments `row_cnt`.
  - After row 3 is accepted: go to STREAM if `vec_cnt` ≠ 0, otherwise go to DRAIN.
- STREAM:
  - `a_ready` = 1.
  - An accepted beat enters the skew stage with tag valid=1. A cycle with no accepted beat inserts zeros with tag valid=0.
  - The beat that brings the accepted count to `vec_cnt` moves the block to DRAIN.
- Skew:
  - Lane k of `a_out` is `a_vec` lane k delayed by 1+k register stages (lane 0: 1 cycle, lane 3: 4 cycles).
  - The valid tag travels alongside each lane.
  - Every lane shifts every cycle in every state. Lanes fed in non-STREAM states receive zero data and tag 0.
- Results: `res_valid[k]` = the lane-k tag delayed by a further ARRAY_LAT cycles.
- DRAIN:
  - Counts ARRAY_LAT+4 cycles with no new input, flushing all tags.
  - Then moves to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `num_vecs`=0 means the job only loads weights.
- `w_row` and `a_vec` are ignored whenever their ready is low.

## Timing
- Reset:
  - The state returns to IDLE from any state.
  - All counters, skew registers, tag registers and outputs go to 0 (`ld_w_id`=0, `w_out`=0, `a_out`=0, `res_valid`=0, `busy`=0, `done`=0).
  - A reset in mid-job discards the job with no `done`.
- `start` at cycle t gives `busy`=1 and `w_ready`=1 at t+1.
- A weight beat accepted at cycle t gives `ld_w_en` at t+1.
- The activation beat accepted at cycle t:
  - appears on `a_out` lane k at t+1+k;
  - raises `res_valid[k]` at t+1+k+ARRAY_LAT.
- Best-case job length with no stalls: 1 + 4 + `num_vecs` + ARRAY_LAT+4 + 1 cycles from `start` to the `done` pulse.
- A row-3 weight beat and the STREAM entry never overlap, so the first `a_ready` is one cycle after row-3 acceptance.
- `done` and a new `start` in the same cycle: the `start` is ignored, because the block is not yet in IDLE.

## Configuration
- `TPU_SEQ_PERF_EN`:
  - Defined: adds outputs `perf_cycles` (16) and `perf_stalls` (16).
  - `perf_cycles` counts cycles while `busy`=1.
  - `perf_stalls` counts LOAD_W/STREAM cycles in which ready=1 and valid=0.
  - Both counters saturate at 0xFFFF, clear on an accepted `start` and on `rst`, and hold after `done`.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset in IDLE, then 3 idle cycles: all outputs 0 and `busy`=0.
- `start`, `num_vecs`=2, weights 0x01/0x02/0x03/0x04 rows, back-to-back vectors with ARRAY_LAT=4:
  - `ld_w_id` goes 0,1,2,3 on 4 consecutive cycles;
  - `res_valid[0]` is high 2 cycles and `res_valid[3]` is high 3 cycles later;
  - `done` at cycle 16.
- Same job with `a_valid` low for 2 cycles between the vectors:
  - a 2-cycle gap in each `res_valid` lane, zeros on `a_out` in the gap;
  - `done` is delayed by 2 cycles;
  - with PERF_EN, `perf_stalls`=2.
- `num_vecs`=0: 4 weight loads, no `a_ready`, `res_valid` stays 0, `done` exactly ARRAY_LAT+5 cycles after the row-3 `ld_w_en`.
- `start` pulsed during STREAM, then `rst` asserted mid-DRAIN: the second `start` is ignored; after `rst` the state is IDLE, `res_valid`=0, and no `done` pulse occurs.
- PERF_EN with a job longer than 65535 cycles: `perf_cycles` holds 0xFFFF.
